// File: rtl/pass_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pass_entry_ctrl
//  Purpose  : Keypad passcode entry FSM: assembles a 4-bit code from bit keys
//             and hands it to the downstream attempt counter on submit.
//  Revision : 1.0  initial release
// ============================================================================
module pass_entry_ctrl #(
    parameter int TIMEOUT  = 1000,
    parameter int HOLD_CYC = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       lockout,
    output logic [3:0] passin,
    output logic       enter,
    output logic [2:0] nbits,
    output logic       entry_err,
    output logic       timeout
);

    localparam int c_ICNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int c_HOLD_N = (HOLD_CYC > 1) ? HOLD_CYC : 1;
    localparam int c_HCNT_W = (c_HOLD_N > 2) ? $clog2(c_HOLD_N) : 1;
    localparam logic [c_ICNT_W-1:0] c_ICNT_LAST = c_ICNT_W'(TIMEOUT - 1);
    localparam logic [c_HCNT_W-1:0] c_HCNT_LAST = c_HCNT_W'(c_HOLD_N - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_READY   = 3'd2,
        S_HOLD    = 3'd3,
        S_LOCK    = 3'd4
    } state_t;

    state_t                r_state, w_state_nx;
    logic [3:0]            r_sr, w_sr_nx;
    logic [2:0]            r_nbits, w_nbits_nx;
    logic [3:0]            r_passin, w_passin_nx;
    logic                  r_enter, w_enter_nx;
    logic                  r_err, w_err_nx;
    logic                  r_to, w_to_nx;
    logic [c_ICNT_W-1:0]   r_icnt, w_icnt_nx, w_icnt_inc;
    logic [c_HCNT_W-1:0]   r_hcnt, w_hcnt_nx;

    logic w_is_bit, w_is_clr, w_is_sub, w_is_bad, w_expire;

    assign w_is_bit = key_valid && (key_code[3:1] == 3'b000);
    assign w_is_clr = key_valid && (key_code == 4'hA);
    assign w_is_sub = key_valid && (key_code == 4'hB);
    assign w_is_bad = key_valid && !(w_is_bit || w_is_clr || w_is_sub);
    // A key in the expiry cycle takes precedence over the timeout.
    assign w_expire = !key_valid && (r_icnt == c_ICNT_LAST);

    assign w_icnt_inc = key_valid ? '0 :
                        (r_icnt == c_ICNT_LAST) ? r_icnt : r_icnt + c_ICNT_W'(1);

    always_comb begin
        w_state_nx  = r_state;
        w_sr_nx     = r_sr;
        w_nbits_nx  = r_nbits;
        w_passin_nx = r_passin;
        w_enter_nx  = 1'b0;
        w_err_nx    = 1'b0;
        w_to_nx     = 1'b0;
        w_icnt_nx   = '0;
        w_hcnt_nx   = '0;

        if (lockout && (r_state != S_HOLD)) begin
            w_state_nx = S_LOCK;
            w_sr_nx    = '0;
            w_nbits_nx = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_bit) begin
                        w_state_nx = S_COLLECT;
                        w_sr_nx    = {r_sr[2:0], key_code[0]};
                        w_nbits_nx = 3'd1;
                    end else if (w_is_bad) begin
                        w_err_nx = 1'b1;
                    end
                end
                S_COLLECT: begin
                    w_icnt_nx = w_icnt_inc;
                    if (w_is_bit) begin
                        w_sr_nx    = {r_sr[2:0], key_code[0]};
                        w_nbits_nx = r_nbits + 3'd1;
                        if (r_nbits == 3'd3) begin
                            w_state_nx = S_READY;
                        end
                    end else if (w_is_clr) begin
                        w_state_nx = S_IDLE;
                        w_sr_nx    = '0;
                        w_nbits_nx = '0;
                    end else if (w_is_sub || w_is_bad) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = S_IDLE;
                        w_sr_nx    = '0;
                        w_nbits_nx = '0;
                    end else if (w_expire) begin
                        w_to_nx    = 1'b1;
                        w_state_nx = S_IDLE;
                        w_sr_nx    = '0;
                        w_nbits_nx = '0;
                    end
                end
                S_READY: begin
                    w_icnt_nx = w_icnt_inc;
                    if (w_is_clr) begin
                        w_state_nx = S_IDLE;
                        w_sr_nx    = '0;
                        w_nbits_nx = '0;
                    end else if (w_is_bad) begin
                        w_err_nx = 1'b1;
                    end else if (w_is_sub) begin
                        w_passin_nx = r_sr;
                        w_enter_nx  = 1'b1;
                        w_state_nx  = S_HOLD;
                    end else if (w_expire) begin
                        w_to_nx    = 1'b1;
                        w_state_nx = S_IDLE;
                        w_sr_nx    = '0;
                        w_nbits_nx = '0;
                    end
                end
                S_HOLD: begin
                    if (r_hcnt == c_HCNT_LAST) begin
                        w_state_nx = lockout ? S_LOCK : S_IDLE;
                        w_sr_nx    = '0;
                        w_nbits_nx = '0;
                    end else begin
                        w_hcnt_nx = r_hcnt + c_HCNT_W'(1);
                    end
                end
                S_LOCK: begin
                    w_state_nx = S_IDLE;
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_sr_nx    = '0;
                    w_nbits_nx = '0;
                end
            endcase
        end

        if ((w_state_nx != S_COLLECT) && (w_state_nx != S_READY)) begin
            w_icnt_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_sr     <= '0;
            r_nbits  <= '0;
            r_passin <= '0;
            r_enter  <= 1'b0;
            r_err    <= 1'b0;
            r_to     <= 1'b0;
            r_icnt   <= '0;
            r_hcnt   <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_sr     <= w_sr_nx;
            r_nbits  <= w_nbits_nx;
            r_passin <= w_passin_nx;
            r_enter  <= w_enter_nx;
            r_err    <= w_err_nx;
            r_to     <= w_to_nx;
            r_icnt   <= w_icnt_nx;
            r_hcnt   <= w_hcnt_nx;
        end
    end

    assign passin    = r_passin;
    assign enter     = r_enter;
    assign nbits     = r_nbits;
    assign entry_err = r_err;
    assign timeout   = r_to;

endmodule
`default_nettype wire
